// File: rtl/audio_pkg.sv
// Shared audio definitions: sequencer state encoding, song-table word layout
// and equal-tempered note frequencies (C4..B5) in whole hertz.
package audio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_PLAY   = 3'd3,
      ST_GAP    = 3'd4,
      ST_PAUSED = 3'd5
   } seq_state_e;

   localparam int DUR_W   = 4;
   localparam int HZ_W    = 12;
   localparam int WORD_W  = 16;
   localparam int DUR_LSB = 12;
   localparam int HZ_LSB  = 0;

   localparam logic [HZ_W-1:0] NOTE_C4  = 12'd262;
   localparam logic [HZ_W-1:0] NOTE_CS4 = 12'd277;
   localparam logic [HZ_W-1:0] NOTE_D4  = 12'd294;
   localparam logic [HZ_W-1:0] NOTE_DS4 = 12'd311;
   localparam logic [HZ_W-1:0] NOTE_E4  = 12'd330;
   localparam logic [HZ_W-1:0] NOTE_F4  = 12'd349;
   localparam logic [HZ_W-1:0] NOTE_FS4 = 12'd370;
   localparam logic [HZ_W-1:0] NOTE_G4  = 12'd392;
   localparam logic [HZ_W-1:0] NOTE_GS4 = 12'd415;
   localparam logic [HZ_W-1:0] NOTE_A4  = 12'd440;
   localparam logic [HZ_W-1:0] NOTE_AS4 = 12'd466;
   localparam logic [HZ_W-1:0] NOTE_B4  = 12'd494;
   localparam logic [HZ_W-1:0] NOTE_C5  = 12'd523;
   localparam logic [HZ_W-1:0] NOTE_CS5 = 12'd554;
   localparam logic [HZ_W-1:0] NOTE_D5  = 12'd587;
   localparam logic [HZ_W-1:0] NOTE_DS5 = 12'd622;
   localparam logic [HZ_W-1:0] NOTE_E5  = 12'd659;
   localparam logic [HZ_W-1:0] NOTE_F5  = 12'd698;
   localparam logic [HZ_W-1:0] NOTE_FS5 = 12'd740;
   localparam logic [HZ_W-1:0] NOTE_G5  = 12'd784;
   localparam logic [HZ_W-1:0] NOTE_GS5 = 12'd831;
   localparam logic [HZ_W-1:0] NOTE_A5  = 12'd880;
   localparam logic [HZ_W-1:0] NOTE_AS5 = 12'd932;
   localparam logic [HZ_W-1:0] NOTE_B5  = 12'd988;

   function automatic logic [WORD_W-1:0] note_word(input logic [DUR_W-1:0] dur,
                                                   input logic [HZ_W-1:0]  hz);
      return {dur, hz};
   endfunction

endpackage

// File: rtl/melody_sequencer_song_rom.sv
// Synchronous-read song table (one-cycle latency) holding the opening of
// "Ode to Joy"; every address past the tune reads as the end-of-song marker.
module song_rom
   import audio_pkg::*;
#(
   parameter int SONG_LEN = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              clk_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [WORD_W-1:0] data_o
);

   logic [WORD_W-1:0] word_s;
   logic [WORD_W-1:0] data_q;

   // Table contents selected by address
   always_comb begin
      word_s = '0;
      case (int'(addr_i))
         0:  word_s = note_word(4'd4, NOTE_E4);
         1:  word_s = note_word(4'd4, NOTE_E4);
         2:  word_s = note_word(4'd4, NOTE_F4);
         3:  word_s = note_word(4'd4, NOTE_G4);
         4:  word_s = note_word(4'd4, NOTE_G4);
         5:  word_s = note_word(4'd4, NOTE_F4);
         6:  word_s = note_word(4'd4, NOTE_E4);
         7:  word_s = note_word(4'd4, NOTE_D4);
         8:  word_s = note_word(4'd4, NOTE_C4);
         9:  word_s = note_word(4'd4, NOTE_C4);
         10: word_s = note_word(4'd4, NOTE_D4);
         11: word_s = note_word(4'd4, NOTE_E4);
         12: word_s = note_word(4'd6, NOTE_E4);
         13: word_s = note_word(4'd2, NOTE_D4);
         14: word_s = note_word(4'd8, NOTE_D4);
         default: word_s = '0;
      endcase
   end

   // Registered read port
   always_ff @(posedge clk_i) begin
      data_q <= word_s;
   end

   assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Walks a (duration, hz) song table and drives the buzzer frequency, with a
// silent articulation gap at the end of every note and start/stop/pause control.
module melody_sequencer
   import audio_pkg::*;
#(
   parameter int UNIT_CYCLES = 6_250_000,
   parameter int GAP_CYCLES  = 500_000,
   parameter int SONG_LEN    = 32,
   parameter int ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [WORD_W-1:0] rom_data,
   output logic [HZ_W-1:0]   hz,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] note_idx
);

   localparam int                CNT_W     = $clog2(15 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

   seq_state_e        state_q, state_d;
   seq_state_e        saved_q, saved_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [HZ_W-1:0]   hz_q, hz_d;
   logic [HZ_W-1:0]   note_q, note_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              end_song_s;

   logic [DUR_W-1:0]  dur_s;
   logic [HZ_W-1:0]   rom_hz_s;
   logic [CNT_W-1:0]  play_load_s;

   assign dur_s       = rom_data[DUR_LSB +: DUR_W];
   assign rom_hz_s    = rom_data[HZ_LSB +: HZ_W];
   assign play_load_s = CNT_W'(32'(dur_s) * 32'(UNIT_CYCLES) - 32'(GAP_CYCLES) - 32'd1);

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      saved_d    = saved_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      idx_d      = idx_q;
      hz_d       = hz_q;
      note_d     = note_q;
      done_d     = 1'b0;
      end_song_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop && !pause) begin
               state_d = ST_FETCH;
               addr_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            if (dur_s == 4'd0) begin
               end_song_s = 1'b1;
            end else begin
               hz_d    = rom_hz_s;
               note_d  = rom_hz_s;
               cnt_d   = play_load_s;
               idx_d   = addr_q;
               state_d = ST_PLAY;
            end
         end
         // A pause still consumes the current cycle, so the note keeps its length
         ST_PLAY: begin
            if (cnt_q == '0) begin
               hz_d    = '0;
               cnt_d   = GAP_LOAD;
               state_d = pause ? ST_PAUSED : ST_GAP;
               saved_d = pause ? ST_GAP : saved_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (pause) begin
                  hz_d    = '0;
                  saved_d = ST_PLAY;
                  state_d = ST_PAUSED;
               end else begin
                  state_d = ST_PLAY;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               if (addr_q == LAST_ADDR) begin
                  end_song_s = 1'b1;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = ST_FETCH;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (pause) begin
                  saved_d = ST_GAP;
                  state_d = ST_PAUSED;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_PAUSED: begin
            if (pause) begin
               state_d = saved_q;
               hz_d    = (saved_q == ST_PLAY) ? note_q : '0;
            end else begin
               state_d = ST_PAUSED;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hz_d    = '0;
         end
      endcase

      if (end_song_s) begin
         addr_d = '0;
         hz_d   = '0;
         if (loop_en) begin
            state_d = ST_FETCH;
         end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end else begin
         done_d = done_d;
      end

      if (stop && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         hz_d    = '0;
         addr_d  = '0;
         done_d  = 1'b0;
      end else begin
         state_d = state_d;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         saved_q <= ST_PLAY;
         cnt_q   <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         hz_q    <= '0;
         note_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         hz_q    <= hz_d;
         note_q  <= note_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rom_addr = addr_q;
   assign note_idx = idx_q;
   assign hz       = hz_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Melody sequencer that walks a song table of (duration, frequency) entries and drives the 12-bit `hz` input of the buzzer player stage. It sits directly upstream of the buzzer player. Edge-detected switch and button pulses give it start, stop and pause control. It emits one frequency per note, a short silent gap between notes for articulation, and `hz = 0` whenever it is not sounding.

## Interface
- `UNIT_CYCLES`, default 6_250_000: clock cycles per duration unit (1/16 s at 100 MHz).
- `GAP_CYCLES`, default 500_000: silent cycles at the end of every note. Must satisfy 0 < `GAP_CYCLES` < `UNIT_CYCLES`.
- `SONG_LEN`, default 32: number of table entries. Must be a power of two, at least 2.
- `ADDR_W`, default 5: log2(`SONG_LEN`).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins playback from entry 0.
- `stop`  in  1  one-cycle pulse; aborts playback.
- `pause`  in  1  one-cycle pulse; toggles between paused and playing.
- `loop_en`  in  1  level; when high, playback restarts at entry 0 instead of finishing.
- `rom_addr`  out  `ADDR_W`  table address.
- `rom_data`  in  16  table word: [15:12] duration in units, [11:0] hz. Duration 0 marks end of song; hz 0 is a rest. Valid one cycle after `rom_addr` is presented.
- `hz`  out  12  frequency for the buzzer player; 0 means silent.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a song ends naturally.
- `note_idx`  out  `ADDR_W`  index of the entry currently playing.

## Operation
- Reset values: state IDLE, `hz`=0, `busy`=0, `done`=0, `rom_addr`=0, `note_idx`=0, counter=0, saved state=PLAY.
- State IDLE:
  - `start` → FETCH with `rom_addr`=0.
  - `stop` and `pause` are ignored.
- State FETCH: hold `rom_addr` for one cycle, then go to LOAD.
- State LOAD (`rom_data` is valid here):
  - If duration = 0 → end of song.
  - Otherwise: `hz` ← `rom_data[11:0]`, counter ← duration×`UNIT_CYCLES` − `GAP_CYCLES` − 1, `note_idx` ← `rom_addr`, then go to PLAY.
- State PLAY:
  - Counter decrements each cycle.
  - At 0: `hz` ← 0, counter ← `GAP_CYCLES` − 1, go to GAP.
- State GAP:
  - At counter 0: if `rom_addr` = `SONG_LEN`−1 → end of song.
  - Otherwise `rom_addr`+1 and go to FETCH.
- End of song:
  - If `loop_en`: `rom_addr` ← 0, go to FETCH, no `done`.
  - Otherwise: go to IDLE, `hz`=0, and pulse `done` in the cycle that enters IDLE.
- State PAUSED:
  - Entered by `pause` from PLAY or GAP. Record which state it came from.
  - `hz`=0 and the counter is frozen.
  - A second `pause` returns to the recorded state. The counter resumes from its frozen value, and `hz` is restored from a held note register.
- `pause` in FETCH or LOAD is ignored.
- `stop` in any non-IDLE state → IDLE next cycle, with `hz`=0, `rom_addr`=0 and no `done`.
- Simultaneous inputs: `stop` beats `pause`, which beats `start`. `start` while `busy` is ignored.
- Counter width: ceil(log2(15×`UNIT_CYCLES`)) bits. Multiply with unsigned arithmetic, zero-extending the 4-bit duration.
- Asserting `rst` mid-note clears everything immediately. `hz` drops to 0 asynchronously.

## Timing
- `start` at edge N: FETCH in cycle N+1, LOAD in N+2, `hz` valid from N+3.
- Note timing: each note of duration d holds `hz` nonzero for exactly d×`UNIT_CYCLES` − `GAP_CYCLES` cycles, then 0 for `GAP_CYCLES` cycles.
- Inter-note overhead is 2 additional silent cycles (FETCH and LOAD).
- `hz`, `busy`, `done`, `rom_addr` and `note_idx` are registered outputs with no combinational path from the inputs.
- `done` lasts exactly one cycle. `busy` falls in the same cycle that `done` rises.

## Structure
- Shared package `audio_pkg`:
  - state encoding: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED.
  - note-field widths and bit positions of the table word.
  - 12-bit note frequency constants C4–B5, for use by song tables and the player test.
- Sub-module `song_rom`:
  - synchronous-read `SONG_LEN`×16 table.
  - one-cycle latency.
  - contents from a case statement over the address.
- The sequencer itself never instantiates the buzzer player. The top level wires `hz` into it.

## Test plan
Use `UNIT_CYCLES`=10, `GAP_CYCLES`=2, `SONG_LEN`=4 and a stub table.
- Playback: table {(1,262),(2,294),(0,0)}, `start` pulse.
  - `hz`=262 for 8 cycles, then 0 for 2+2 cycles.
  - `hz`=294 for 18 cycles.
  - `done` pulse, then `busy`=0.
- Pause/resume: `pause` 3 cycles into the first note, held 20 cycles, then `pause` again.
  - `hz`=0 while paused.
  - After resume, `hz`=262 for exactly the remaining 5 cycles.
- Wrap with loop: table of 4 notes with no end marker and `loop_en`=1.
  - After entry 3's gap, `rom_addr` returns to 0 and entry 0 replays.
  - No `done`.
  - With `loop_en`=0, `done` fires after entry 3.
- Stop priority: `stop` and `pause` in the same cycle mid-note → IDLE next cycle, `hz`=0, no `done`. A subsequent `start` replays from entry 0.
- Rest and reset: entry (2,0) yields `hz`=0 for 20 cycles with `busy`=1. Asserting `rst` during a note gives all outputs at reset values before the next edge.
